ctrl_pipeline: RTL

Pipelined control unit for the 5-stage RV32I(+M) core. It decodes ID-stage instruction fields into the full control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It generates load-use stalls, multi-cycle MDU stalls, branch/jump flushes and EX-stage forwarding selects. It replaces the purely combinational decoder and sits beside the datapath pipeline registers, which consume its stall and flush outputs.

---
 rtl/ctrl_pipeline.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipeline.sv
// Pipelined control unit: decodes ID fields into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, generating stalls, flushes and forwarding selects.
module ctrl_pipeline #(
    parameter bit MDU_EN  = 1'b1,
    parameter int MDU_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             func7_0,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             ex_redirect,
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             ex_valid,
    output logic             ex_alusrc,
    output logic             ex_lui,
    output logic             ex_utype,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic             ex_mdu,
    output logic [5:0]       ex_br,
    output logic [3:0]       ex_aluctl,
    output logic [2:0]       ex_mduop,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_regwrite,
    output logic             mem_memtoreg,
    output logic [2:0]       mem_rwtype,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic [REG_W-1:0] wb_rd
);

    localparam int CNT_W = $clog2(MDU_LAT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic             valid;
        logic             alusrc;
        logic             lui;
        logic             utype;
        logic             jal;
        logic             jalr;
        logic             mdu;
        logic [5:0]       br;
        logic [3:0]       aluctl;
        logic [2:0]       mduop;
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic             memtoreg;
        logic [2:0]       rwtype;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    ctrl_t            id_ctl;
    ctrl_t            ex_q;
    ctrl_t            bubble;
    logic [1:0]       aluop;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             lu;
    logic             redirect;
    logic             busy;
    logic             mdu_start;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        bubble        = '0;
        bubble.aluctl = ALU_ADD;
    end

    always_comb begin
        id_ctl        = '0;
        id_ctl.aluctl = ALU_ADD;
        aluop         = 2'b00;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        if (id_valid) begin
            id_ctl.valid  = 1'b1;
            id_ctl.rs1    = rs1;
            id_ctl.rs2    = rs2;
            id_ctl.rd     = rd;
            id_ctl.rwtype = func3;
            case (opcode)
                OP_R: begin
                    id_ctl.regwrite = 1'b1;
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                    if (MDU_EN && func7_0) begin
                        id_ctl.mdu   = 1'b1;
                        id_ctl.mduop = func3;
                    end else begin
                        aluop = 2'b10;
                    end
                end
                OP_I: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    uses_rs1        = 1'b1;
                    aluop           = 2'b11;
                end
                OP_LOAD: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.memread  = 1'b1;
                    id_ctl.memtoreg = 1'b1;
                    uses_rs1        = 1'b1;
                end
                OP_STORE: begin
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.memwrite = 1'b1;
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                end
                OP_BRANCH: begin
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                    aluop    = 2'b01;
                    case (func3)
                        3'b000:  id_ctl.br = 6'b000001;
                        3'b001:  id_ctl.br = 6'b000010;
                        3'b100:  id_ctl.br = 6'b000100;
                        3'b101:  id_ctl.br = 6'b001000;
                        3'b110:  id_ctl.br = 6'b010000;
                        3'b111:  id_ctl.br = 6'b100000;
                        default: id_ctl.br = 6'b000000;
                    endcase
                end
                OP_JAL: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.jal      = 1'b1;
                end
                OP_JALR: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.jalr     = 1'b1;
                    uses_rs1        = 1'b1;
                end
                OP_LUI: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.lui      = 1'b1;
                    id_ctl.utype    = 1'b1;
                end
                OP_AUIPC: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.utype    = 1'b1;
                end
                default: ;
            endcase
            // func7 only selects an alternate op for R-type and for I-type shifts-right
            case (aluop)
                2'b01: begin
                    case (func3)
                        3'b100, 3'b101: id_ctl.aluctl = ALU_SLT;
                        3'b110, 3'b111: id_ctl.aluctl = ALU_SLTU;
                        default:        id_ctl.aluctl = ALU_SUB;
                    endcase
                end
                2'b10:   id_ctl.aluctl = {func7, func3};
                2'b11:   id_ctl.aluctl = (func3 == 3'b101) ? {func7, func3} : {1'b0, func3};
                default: id_ctl.aluctl = ALU_ADD;
            endcase
        end
    end

    assign busy     = (state == BUSY);
    assign lu       = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                      ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));
    assign redirect = ex_redirect && ex_q.valid && !busy;

    assign stall_if   = !rst && (busy || (!redirect && lu));
    assign flush_ifid = !rst && redirect;

    assign mdu_start = !busy && !redirect && !lu && id_ctl.valid && id_ctl.mdu && (MDU_LAT > 1);

    // MDU occupancy: counts down the extra EX cycles of a mul/div op
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MDU_LAT - 1);
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // On the last BUSY cycle the op leaves EX while IF/ID is still held, so EX takes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= bubble;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_rwtype   <= '0;
            mem_rd       <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            wb_regwrite <= mem_regwrite;
            wb_memtoreg <= mem_memtoreg;
            wb_rd       <= mem_rd;

            if (busy && (cnt != CNT_W'(1))) begin
                mem_memread  <= 1'b0;
                mem_memwrite <= 1'b0;
                mem_regwrite <= 1'b0;
                mem_memtoreg <= 1'b0;
                mem_rwtype   <= '0;
                mem_rd       <= '0;
            end else begin
                mem_memread  <= ex_q.memread;
                mem_memwrite <= ex_q.memwrite;
                mem_regwrite <= ex_q.regwrite;
                mem_memtoreg <= ex_q.memtoreg;
                mem_rwtype   <= ex_q.rwtype;
                mem_rd       <= ex_q.rd;
            end

            if (busy) begin
                if (cnt == CNT_W'(1)) begin
                    ex_q <= bubble;
                end
            end else if (redirect || lu) begin
                ex_q <= bubble;
            end else begin
                ex_q <= id_ctl;
            end
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_alusrc = ex_q.alusrc;
    assign ex_lui    = ex_q.lui;
    assign ex_utype  = ex_q.utype;
    assign ex_jal    = ex_q.jal;
    assign ex_jalr   = ex_q.jalr;
    assign ex_mdu    = ex_q.mdu;
    assign ex_br     = ex_q.br;
    assign ex_aluctl = ex_q.aluctl;
    assign ex_mduop  = ex_q.mduop;
    assign ex_rs1    = ex_q.rs1;
    assign ex_rs2    = ex_q.rs2;
    assign ex_rd     = ex_q.rd;

    assign fwd_a = (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_q.rs1)) ? 2'b10 :
                   (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_q.rs1)) ? 2'b01 : 2'b00;
    assign fwd_b = (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_q.rs2)) ? 2'b10 :
                   (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_q.rs2)) ? 2'b01 : 2'b00;

endmodule
